// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: one shared adder, iterative shift-add multiply, valid/ready handshakes.
// Optional build macro ALU_SEQ_MULT_EARLY_EXIT_EN ends a multiply once the remaining multiplier is zero.
module alu_seq_ctrl #(
  parameter int REG_BITS = 32,
  parameter int CNT_BITS = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                alu_op,
  input  logic                alu_src,
  input  logic [2:0]          opcode2,
  input  logic [REG_BITS-1:0] operand1,
  input  logic [REG_BITS-1:0] operand2,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [REG_BITS-1:0] result,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OPC_ADD  = 3'b000;
  localparam logic [2:0] OPC_SUB  = 3'b001;
  localparam logic [2:0] OPC_NEG  = 3'b010;
  localparam logic [2:0] OPC_MULT = 3'b011;
  localparam logic [2:0] OPC_AND  = 3'b100;
  localparam logic [2:0] OPC_OR   = 3'b101;
  localparam logic [2:0] OPC_XOR  = 3'b110;
  localparam logic [2:0] OPC_NOT  = 3'b111;
  localparam logic [2:0] CMP_EQ   = 3'b000;
  localparam logic [2:0] CMP_GT   = 3'b001;
  localparam logic [2:0] CMP_LEQ  = 3'b010;

  localparam logic [REG_BITS-1:0] ZERO_W   = {REG_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(REG_BITS - 1);

  function automatic logic [REG_BITS-1:0] zext1(input logic b);
    return {{(REG_BITS-1){1'b0}}, b};
  endfunction

  state_t                state_r;
  state_t                state_next_s;
  logic                  op_r;
  logic                  src_r;
  logic [2:0]            opc_r;
  // op1_r doubles as the multiplicand and op2_r as the multiplier during MULT
  logic [REG_BITS-1:0]   op1_r;
  logic [REG_BITS-1:0]   op2_r;
  logic [REG_BITS-1:0]   acc_r;
  logic [CNT_BITS-1:0]   cnt_r;
  logic [REG_BITS-1:0]   result_r;
  logic                  resp_valid_r;
  logic                  req_ready_r;
  logic                  busy_r;

  logic                  accept_s;
  logic                  is_mult_s;
  logic                  mult_last_s;
  logic [REG_BITS-1:0]   add_a_s;
  logic [REG_BITS-1:0]   add_b_s;
  logic                  add_cin_s;
  logic [REG_BITS-1:0]   sum_s;
  logic [REG_BITS-1:0]   sel_s;
  logic [REG_BITS-1:0]   exec_res_s;
  logic [REG_BITS-1:0]   acc_next_s;
  logic [REG_BITS-1:0]   mplier_next_s;

  assign accept_s      = req_valid && (state_r == ST_IDLE);
  assign is_mult_s     = (alu_op == 1'b0) && (opcode2 == OPC_MULT);
  assign sel_s         = src_r ? op2_r : op1_r;
  assign sum_s         = add_a_s + add_b_s + zext1(add_cin_s);
  assign acc_next_s    = op2_r[0] ? sum_s : acc_r;
  assign mplier_next_s = {1'b0, op2_r[REG_BITS-1:1]};

`ifdef ALU_SEQ_MULT_EARLY_EXIT_EN
  assign mult_last_s = (cnt_r == CNT_LAST) || (mplier_next_s == ZERO_W);
`else
  assign mult_last_s = (cnt_r == CNT_LAST);
`endif

  assign req_ready  = req_ready_r;
  assign busy       = busy_r;
  assign resp_valid = resp_valid_r;
  assign result     = result_r;

  // Shared adder operand steering: comparator computes op2 - op1, sub computes op1 - op2
  always_comb begin
    add_a_s   = op1_r;
    add_b_s   = op2_r;
    add_cin_s = 1'b0;
    if (state_r == ST_MULT) begin
      add_a_s = acc_r;
      add_b_s = op1_r;
    end else if (op_r) begin
      add_a_s   = op2_r;
      add_b_s   = ~op1_r;
      add_cin_s = 1'b1;
    end else if (opc_r == OPC_SUB) begin
      add_b_s   = ~op2_r;
      add_cin_s = 1'b1;
    end else begin
      add_a_s   = op1_r;
      add_b_s   = op2_r;
      add_cin_s = 1'b0;
    end
  end

  // Single-cycle result selection for the EXEC state
  always_comb begin
    exec_res_s = ZERO_W;
    if (op_r) begin
      case (opc_r)
        CMP_EQ:  exec_res_s = zext1(op1_r == op2_r);
        CMP_GT:  exec_res_s = zext1(sum_s[REG_BITS-1]);
        CMP_LEQ: exec_res_s = zext1(~sum_s[REG_BITS-1]);
        default: exec_res_s = ZERO_W;
      endcase
    end else begin
      case (opc_r)
        OPC_ADD:  exec_res_s = sum_s;
        OPC_SUB:  exec_res_s = sum_s;
        OPC_NEG:  exec_res_s = ~sel_s;
        OPC_MULT: exec_res_s = ZERO_W;
        OPC_AND:  exec_res_s = op1_r & op2_r;
        OPC_OR:   exec_res_s = op1_r | op2_r;
        OPC_XOR:  exec_res_s = op1_r ^ op2_r;
        OPC_NOT:  exec_res_s = zext1(sel_s == ZERO_W);
        default:  exec_res_s = ZERO_W;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = is_mult_s ? ST_MULT : ST_EXEC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: state_next_s = ST_DONE;
      ST_MULT: begin
        if (mult_last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_MULT;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath registers, handshake outputs and the multiply loop
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_r         <= 1'b0;
      src_r        <= 1'b0;
      opc_r        <= 3'b000;
      op1_r        <= ZERO_W;
      op2_r        <= ZERO_W;
      acc_r        <= ZERO_W;
      cnt_r        <= CNT_ZERO;
      result_r     <= ZERO_W;
      resp_valid_r <= 1'b0;
      req_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      req_ready_r <= (state_next_s == ST_IDLE);
      busy_r      <= (state_next_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r  <= alu_op;
            src_r <= alu_src;
            opc_r <= opcode2;
            op1_r <= operand1;
            op2_r <= operand2;
            acc_r <= ZERO_W;
            cnt_r <= CNT_ZERO;
          end
        end
        ST_EXEC: begin
          result_r     <= exec_res_s;
          resp_valid_r <= 1'b1;
        end
        ST_MULT: begin
          acc_r <= acc_next_s;
          op1_r <= {op1_r[REG_BITS-2:0], 1'b0};
          op2_r <= mplier_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (mult_last_s) begin
            result_r     <= acc_next_s;
            resp_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer wrapping the stack machine's ALU function set (arithmetic group 1/2, comparator group 5).
- Built around one shared REG_BITS-wide adder. Multiply is iterative shift-add, so the full datapath needs no combinational multiplier.
- Sits between decode/stack logic and the writeback mux.
- Uses a valid/ready request and response handshake so the core can stall on long ops.

Parameters:
- REG_BITS, 32: operand and result width.
- CNT_BITS, 6: iteration counter width; must satisfy 2^CNT_BITS > REG_BITS.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- alu_op  in  1  0 = arithmetic, 1 = comparator.
- alu_src  in  1  unary operand select: 0 = operand1, 1 = operand2.
- opcode2  in  3  function code.
- operand1  in  REG_BITS  first operand.
- operand2  in  REG_BITS  second operand.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- result  out  REG_BITS  registered result.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (reset_n = 0 at a rising edge):
  - state = IDLE; result = 0; resp_valid = 0; internal registers = 0.
  - Reset mid-operation aborts the operation. No response is ever produced for it.
- Accept: req_valid && req_ready at edge A latches alu_op, alu_src, opcode2, operand1 and operand2. Inputs are don't-care afterwards.
- States:
  - IDLE: on accept, go to EXEC, unless arithmetic opcode 3'b011, which goes to MULT.
  - EXEC: one cycle. Compute the result, register it at edge A+1, go to DONE.
  - MULT: shift-add loop. Initial state: acc = 0, mcand = op1, mplier = op2, cnt = 0.
    - Each edge: if mplier[0], acc = acc + mcand; then mcand <<= 1, mplier >>= 1, cnt++.
    - After REG_BITS iterations (edge A+REG_BITS), result = acc (low REG_BITS bits) and go to DONE.
  - DONE: resp_valid = 1; result is held stable. On resp_ready, go to IDLE at that edge and clear resp_valid.
- Latency:
  - resp_valid first high after edge A+1 for non-multiply ops.
  - resp_valid first high after edge A+REG_BITS for multiply.
  - Back-to-back throughput: one op per 3 cycles for non-multiply ops when resp_ready is held high.
- Arithmetic functions (alu_op = 0), all modulo 2^REG_BITS:
  - 000 add: op1 + op2.
  - 001 sub: op1 + ~op2 + 1.
  - 010 neg: bitwise ~sel, where sel = alu_src ? op2 : op1.
  - 011 mult: low half of the product.
  - 100 and; 101 or; 110 xor.
  - 111 not: 1 if sel == 0, else 0 (zero-extended).
- Comparator functions (alu_op = 1):
  - d = op2 + ~op1 + 1 (mod 2^REG_BITS).
  - 000 eq: result = (op1 == op2).
  - 001 gt: result = d[MSB].
  - 010 leq: result = ~d[MSB].
  - 011–111: result = 0.
  - Results are zero-extended 1-bit values.
- Single adder: add, sub, gt, leq and each multiply step all use the same adder instance. Operand muxing is driven by the state and the latched opcode.
- Boundaries:
  - req_valid is ignored while busy; the request is not consumed.
  - resp_ready while not in DONE has no effect.
  - Overflow wraps silently.
  - Multiply by 0 still takes the full REG_BITS iterations unless the optional feature is enabled.

Optional Feature:
- Macro: ALU_SEQ_MULT_EARLY_EXIT_EN.
- Defined: MULT goes to DONE at the first edge after which the shifted mplier == 0, checked after each iteration. If op2 == 0 at accept, MULT goes to DONE at edge A+1 with result 0.
- Undefined: fixed REG_BITS iterations, and latency is deterministic.
- The result value is identical in both builds.

Test Plan:
- Reset and idle:
  - reset_n low for 2 cycles mid-MULT, then high.
  - Required: resp_valid = 0, result = 0, req_ready = 1; no response emitted for the aborted op.
- Add wrap:
  - add 0xFFFFFFFF + 0x00000002.
  - Required: result 0x00000001; resp_valid rises after edge A+1.
  - Then sub 5 − 7 → 0xFFFFFFFE.
- Multiply (REG_BITS = 32):
  - 0x00010001 × 0x00000003 → 0x00030003, with resp_valid after edge A+32.
  - 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001.
  - With the feature: ×3 completes at edge A+2, ×0 at edge A+1.
- Comparator:
  - eq 7,7 → 1.
  - gt op1 = 9, op2 = 4 → 1.
  - leq op1 = 9, op2 = 4 → 0.
  - leq 4,4 → 1.
  - alu_op = 1, opcode2 = 3'b101 → 0.
- Unary select:
  - neg, alu_src = 1, op2 = 0x0000000F → 0xFFFFFFF0.
  - not, alu_src = 0, op1 = 0 → 1.
  - not, op1 = 5 → 0.
- Backpressure:
  - Hold resp_ready = 0 for 10 cycles in DONE while req_valid = 1 with new operands.
  - Required: result stable, req_ready = 0, second request not accepted.
  - Raise resp_ready: IDLE next edge, then the second request is accepted.
